// File: rtl/fetch_sequencer.sv
// Purpose : instruction fetch stage; owns the PC, drives a sync-read imem, feeds the decoder.
// Latency : imem data returns one cycle after imem_addr; taken redirects cost one bubble.
// Backpressure: none; one slot per cycle. Redirects are sampled only on valid slots.
//
// Ports: clk/reset (sync, active-high); start/done program handshake;
//        br_take/call/ret + br_target redirect inputs from the branch unit;
//        imem_addr/imem_data instruction memory; instr/instr_valid/pc to the decoder;
//        running/halted status; rs_err sticky return-stack overflow/underflow flag.
// Optional: FETCH_RETIRE_CNT_EN adds retire_cnt[15:0], a saturating count of valid slots.
module fetch_sequencer #(
  parameter int          PC_W     = 10,
  parameter int unsigned RESET_PC = 0,
  parameter int          RS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            done,
  input  logic            br_take,
  input  logic [PC_W-1:0] br_target,
  input  logic            call,
  input  logic            ret,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_data,
  output logic [8:0]      instr,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            halted,
`ifdef FETCH_RETIRE_CNT_EN
  output logic [15:0]     retire_cnt,
`endif
  output logic            rs_err
);

  localparam int              SP_W   = $clog2(RS_DEPTH);
  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);
  localparam logic [SP_W:0]   RS_FULL = (SP_W+1)'(RS_DEPTH);
  localparam logic [8:0]      NOP    = 9'h1F4;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] fpc_q, fpc_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            pcv_q, pcv_d;     // valid tag travelling with pc_q
  logic            rs_err_q, rs_err_d;
  logic [SP_W:0]   sp_q, sp_d;       // entries held, 0..RS_DEPTH
  logic [SP_W-1:0] top_q, top_d;     // next slot to write (circular)
  logic [PC_W-1:0] rs_q [RS_DEPTH];
  logic [PC_W-1:0] rs_d [RS_DEPTH];

  logic            slot_vld;
  logic            start_acc;
  logic [SP_W-1:0] top_m1;
  logic [PC_W-1:0] pop_addr;

  assign slot_vld  = (state_q == S_RUN) && pcv_q;
  assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_HALT));
  assign top_m1    = top_q - 1'b1;
  // Popping an empty stack falls back to the program entry point.
  assign pop_addr  = (sp_q == '0) ? RST_PC : rs_q[top_m1];

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    pc_d     = fpc_q;
    pcv_d    = 1'b0;
    rs_err_d = rs_err_q;
    sp_d     = sp_q;
    top_d    = top_q;
    rs_d     = rs_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start_acc) begin
          state_d = S_FILL;
          fpc_d   = RST_PC;
        end
      end
      S_FILL: begin
        state_d = S_RUN;
        fpc_d   = fpc_q + 1'b1;
        pcv_d   = 1'b1;
      end
      S_RUN: begin
        fpc_d = fpc_q + 1'b1;
        pcv_d = 1'b1;
        if (slot_vld) begin
          if (done) begin
            // Halt freezes the fetch address and drops the in-flight word.
            state_d = S_HALT;
            fpc_d   = fpc_q;
            pcv_d   = 1'b0;
          end else if (ret) begin
            fpc_d = pop_addr;
            pcv_d = 1'b0;
            if (sp_q == '0) begin
              rs_err_d = 1'b1;
            end else begin
              sp_d  = sp_q - 1'b1;
              top_d = top_m1;
            end
          end else if (call) begin
            rs_d[top_q] = pc_q + 1'b1;
            top_d       = top_q + 1'b1;
            // A full stack keeps its depth; the write above replaced the oldest entry.
            if (sp_q == RS_FULL) rs_err_d = 1'b1;
            else                 sp_d     = sp_q + 1'b1;
            fpc_d = br_target;
            pcv_d = 1'b0;
          end else if (br_take) begin
            fpc_d = br_target;
            pcv_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      fpc_q    <= RST_PC;
      pc_q     <= RST_PC;
      pcv_q    <= 1'b0;
      rs_err_q <= 1'b0;
      sp_q     <= '0;
      top_q    <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      pc_q     <= pc_d;
      pcv_q    <= pcv_d;
      rs_err_q <= rs_err_d;
      sp_q     <= sp_d;
      top_q    <= top_d;
    end
  end

  // Stack contents need no reset: entries are only read after being written
  // or when sp_q says the stack is empty.
  always_ff @(posedge clk) begin
    rs_q <= rs_d;
  end

`ifdef FETCH_RETIRE_CNT_EN
  logic [15:0] retire_q, retire_d;

  always_comb begin
    retire_d = retire_q;
    if (start_acc)                              retire_d = '0;
    else if (slot_vld && (retire_q != 16'hFFFF)) retire_d = retire_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) retire_q <= '0;
    else       retire_q <= retire_d;
  end

  assign retire_cnt = retire_q;
`endif

  assign imem_addr   = fpc_q;
  assign instr_valid = slot_vld;
  assign instr       = slot_vld ? imem_data : NOP;
  assign pc          = pc_q;
  assign running     = (state_q == S_FILL) || (state_q == S_RUN);
  assign halted      = (state_q == S_HALT);
  assign rs_err      = rs_err_q;

endmodule
